// File: rtl/stim_check_pkg.sv
// stim_check_pkg: FSM states, stimulus mode encodings and the LFSR step shared by stim_check_gen.
package stim_check_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  localparam int MODE_INV  = 0;
  localparam int MODE_INC  = 1;
  localparam int MODE_LFSR = 2;
  // Shift left with feedback = XOR of the two top bits; a single-bit lane simply toggles.
  function automatic logic [63:0] lfsr_step(input logic [63:0] v, input int unsigned w);
    logic [63:0] fb;
    fb = ((v >> (w - 1)) ^ (v >> (w - 2))) & 64'd1;
    return (w < 2) ? ~v & 64'd1 : ((v << 1) | fb) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/stim_delay_line.sv
// stim_delay_line: strobe-gated shift register aligning issued vectors with the DUT response.
module stim_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sr_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (en_i) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/stim_check_gen.sv
// stim_check_gen: multi-lane stimulus generator with latency-aligned response checker.
module stim_check_gen
  import stim_check_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int CHANNELS    = 1,
  parameter int LATENCY     = 1,
  parameter int NUM_VECTORS = 10000,
  parameter int MODE        = 0,
  parameter int CNT_W       = 16,
  localparam int CW         = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      en_i,
  output logic [WIDTH*CHANNELS-1:0] stim_o,
  input  logic [WIDTH*CHANNELS-1:0] dut_out_i,
  output logic [CNT_W-1:0]          err_count_o,
  output logic                      fail_o,
  output logic [CW-1:0]             first_err_chan_o,
  output logic [31:0]               first_err_vec_o,
  output logic                      busy_o,
  output logic                      done_o
);
  localparam int N  = WIDTH * CHANNELS;
  localparam int DW = N + 33;
  localparam int SW = CNT_W + $clog2(CHANNELS + 1) + 1;
  state_e state_q, state_d;
  logic [N-1:0] stim_q, stim_d, seed, adv, tail_data;
  logic [31:0] vec_q, vec_d, tail_vec, fvec_q, fvec_d;
  logic [4:0] drn_q, drn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CW-1:0] fchan_q, fchan_d, lo_chan;
  logic [CHANNELS-1:0] mis;
  logic [SW-1:0] pop, sum;
  logic fail_q, fail_d, clr, push_v, step, cmp, tail_v, latch;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign seed[c*WIDTH +: WIDTH] = WIDTH'(MODE == MODE_LFSR ? c + 1 : c);
    assign adv[c*WIDTH +: WIDTH]  = MODE == MODE_INV ? ~stim_q[c*WIDTH +: WIDTH] :
                                    MODE == MODE_INC ? stim_q[c*WIDTH +: WIDTH] + WIDTH'(1) :
                                    WIDTH'(lfsr_step(64'(stim_q[c*WIDTH +: WIDTH]), WIDTH));
    assign mis[c] = tail_data[c*WIDTH +: WIDTH] != dut_out_i[c*WIDTH +: WIDTH];
  end
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    drn_d   = drn_q;
    clr     = 1'b0;
    push_v  = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr     = 1'b1;
        state_d = start_i ? S_RUN : S_IDLE;
      end
      S_RUN: if (en_i) begin
        push_v = 1'b1;
        vec_d  = vec_q + 32'd1;
        if (vec_q == 32'(NUM_VECTORS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: if (en_i) begin
        drn_d = drn_q + 5'd1;
        if (drn_q == 5'(LATENCY - 1)) state_d = S_DONE;
      end
      default: if (start_i) begin
        clr     = 1'b1;
        state_d = S_RUN;
      end
    endcase
    if (clr) begin
      vec_d = '0;
      drn_d = '0;
    end
  end
  assign step   = en_i && (state_q == S_RUN || state_q == S_DRAIN);
  assign cmp    = step && tail_v;
  assign stim_d = clr ? seed : push_v ? adv : stim_q;
  // Scanning downward leaves the lowest mismatching channel as the winner.
  always_comb begin
    pop     = '0;
    lo_chan = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mis[i]) lo_chan = CW'(i);
      pop = pop + SW'(mis[i]);
    end
    sum     = SW'(err_q) + pop;
    latch   = cmp && |mis && !fail_q;
    err_d   = clr ? '0 : !cmp ? err_q : sum > SW'({CNT_W{1'b1}}) ? '1 : CNT_W'(sum);
    fail_d  = clr ? 1'b0 : fail_q | (cmp && |mis);
    fchan_d = clr ? '0 : latch ? lo_chan : fchan_q;
    fvec_d  = clr ? '0 : latch ? tail_vec : fvec_q;
  end
  stim_delay_line #(.W(DW), .DEPTH(LATENCY)) u_dl (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .en_i  (step),
    .d_i   ({push_v, vec_q, stim_q}),
    .q_o   ({tail_v, tail_vec, tail_data})
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stim_q  <= seed;
      vec_q   <= '0;
      drn_q   <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      fchan_q <= '0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      vec_q   <= vec_d;
      drn_q   <= drn_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      fchan_q <= fchan_d;
      fvec_q  <= fvec_d;
    end
  end
  assign stim_o           = stim_q;
  assign err_count_o      = err_q;
  assign fail_o           = fail_q;
  assign first_err_chan_o = fchan_q;
  assign first_err_vec_o  = fvec_q;
  assign busy_o           = state_q == S_RUN || state_q == S_DRAIN;
  assign done_o           = state_q == S_DONE;
endmodule

// File: tb/tb_stim_check_gen.sv
// tb_stim_check_gen: three generator configurations driven against emulated DUTs and an arithmetic model.
module tb_stim_check_gen;
  localparam int NV = 20;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, en = 1'b0, start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [11:0] stim_a, p1 = '0, p2 = '0;
  logic [15:0] err_a;
  logic [1:0] fch_a;
  logic [31:0] fvec_a, fvec_b, fvec_c;
  logic fail_a, busy_a, done_a;
  logic [9:0] stim_b;
  logic [2:0] err_b;
  logic [0:0] fch_b, fch_c, stim_c, pc = '0;
  logic fail_b, busy_b, done_b;
  logic [15:0] err_c;
  logic fail_c, busy_c, done_c;
  logic [11:0] fm [32];
  int s = 0;
  int passed = 0, total = 0;
  int errh [64];

  stim_check_gen #(.WIDTH(4), .CHANNELS(3), .LATENCY(2), .NUM_VECTORS(NV), .MODE(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .start_i(start_a), .en_i(en), .stim_o(stim_a), .dut_out_i(p2),
    .err_count_o(err_a), .fail_o(fail_a), .first_err_chan_o(fch_a), .first_err_vec_o(fvec_a),
    .busy_o(busy_a), .done_o(done_a));
  stim_check_gen #(.WIDTH(5), .CHANNELS(2), .LATENCY(3), .NUM_VECTORS(NV), .MODE(2), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .start_i(start_b), .en_i(en), .stim_o(stim_b), .dut_out_i(10'd0),
    .err_count_o(err_b), .fail_o(fail_b), .first_err_chan_o(fch_b), .first_err_vec_o(fvec_b),
    .busy_o(busy_b), .done_o(done_b));
  stim_check_gen #(.WIDTH(1), .CHANNELS(1), .LATENCY(1), .NUM_VECTORS(8), .MODE(0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .start_i(start_c), .en_i(en), .stim_o(stim_c), .dut_out_i(pc),
    .err_count_o(err_c), .fail_o(fail_c), .first_err_chan_o(fch_c), .first_err_vec_o(fvec_c),
    .busy_o(busy_c), .done_o(done_c));

  // Emulated DUTs: a two-stage pipe with a per-vector fault mask for A, a one-stage register for C.
  always @(posedge clk) begin
    if (en && busy_a) begin
      p1 <= stim_a ^ fm[s];
      p2 <= p1;
      s  <= s + 1;
    end else if (!busy_a) s <= 0;
  end
  always @(posedge clk) if (en) pc <= stim_c;

  task automatic tick(input logic e);
    en = e;
    @(negedge clk);
  endtask

  function automatic logic [11:0] seq_a(input int k);
    return {4'((2 + k) % 16), 4'((1 + k) % 16), 4'(k % 16)};
  endfunction

  task automatic model_a(output int e, output int ch, output int vec, output logic f);
    e = 0; ch = 0; vec = 0; f = 1'b0;
    for (int v = 0; v < NV; v++)
      for (int c = 0; c < 3; c++)
        if (((fm[v] >> (4 * c)) & 12'hF) != 12'h0) begin
          e++;
          if (!f) begin f = 1'b1; ch = c; vec = v; end
        end
  endtask

  task automatic run_a(input bit sparse, input bit poke);
    int e, ch, vec;
    logic f;
    logic [11:0] exp;
    start_a = 1'b1;
    tick(0);
    start_a = 1'b0;
    total++; if (busy_a !== 1'b1) $display("FAIL a_busy_start: got %b want 1", busy_a); else passed++;
    for (int k = 0; k < NV + 2; k++) begin
      if (sparse) repeat ($urandom_range(0, 3)) tick(0);
      start_a = poke && k == 7;
      if (k == NV + 1) begin
        total++; if (done_a !== 1'b0) $display("FAIL a_done_early: got %b want 0", done_a); else passed++;
      end
      tick(1);
      start_a = 1'b0;
      errh[k] = int'(err_a);
      exp = seq_a(k < NV ? k + 1 : NV);
      total++; if (stim_a !== exp) $display("FAIL a_stim k=%0d: got %h want %h", k, stim_a, exp); else passed++;
    end
    en = 1'b0;
    model_a(e, ch, vec, f);
    total++; if (done_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL a_done: got done=%b busy=%b want 1/0", done_a, busy_a); else passed++;
    total++; if (err_a !== 16'(e)) $display("FAIL a_err_count: got %0d want %0d", err_a, e); else passed++;
    total++; if (fail_a !== f) $display("FAIL a_fail: got %b want %b", fail_a, f); else passed++;
    total++; if (fch_a !== 2'(ch)) $display("FAIL a_first_chan: got %0d want %0d", fch_a, ch); else passed++;
    total++; if (fvec_a !== 32'(vec)) $display("FAIL a_first_vec: got %0d want %0d", fvec_a, vec); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1); tick(1);
    rst = 1'b0;
    tick(1);
    tick(0);
    total++; if (stim_a !== 12'h210) $display("FAIL rst_stim_a: got %h want 210", stim_a); else passed++;
    total++; if (stim_b !== {5'd2, 5'd1}) $display("FAIL rst_stim_b: got %h want %h", stim_b, {5'd2, 5'd1}); else passed++;
    total++; if (stim_c !== 1'b0) $display("FAIL rst_stim_c: got %b want 0", stim_c); else passed++;
    total++; if (err_a !== 16'd0 || fail_a !== 1'b0) $display("FAIL rst_err: got %0d/%b want 0/0", err_a, fail_a); else passed++;
    total++; if (fch_a !== 2'd0 || fvec_a !== 32'd0) $display("FAIL rst_first: got %0d/%0d want 0/0", fch_a, fvec_a); else passed++;
    total++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL rst_busy_done: got %b/%b want 0/0", busy_a, done_a); else passed++;
  endtask

  task automatic test_invert();
    start_c = 1'b1;
    tick(0);
    start_c = 1'b0;
    for (int k = 0; k < 9; k++) begin
      total++; if (done_c !== 1'b0) $display("FAIL c_done_early k=%0d: got %b want 0", k, done_c); else passed++;
      tick(1);
      total++; if (stim_c !== 1'(k < 8 ? (k + 1) % 2 : 0)) $display("FAIL c_stim k=%0d: got %b want %0d", k, stim_c, k < 8 ? (k + 1) % 2 : 0); else passed++;
    end
    en = 1'b0;
    total++; if (done_c !== 1'b1 || busy_c !== 1'b0) $display("FAIL c_done: got %b/%b want 1/0", done_c, busy_c); else passed++;
    total++; if (err_c !== 16'd0 || fail_c !== 1'b0) $display("FAIL c_result: got %0d/%b want 0/0", err_c, fail_c); else passed++;
  endtask

  task automatic test_lfsr_sat();
    int x0, x1, e;
    x0 = 1; x1 = 2; e = 0;
    start_b = 1'b1;
    tick(0);
    start_b = 1'b0;
    for (int k = 0; k < NV + 3; k++) begin
      tick(1);
      if (k < NV) begin
        e += int'(x0 != 0) + int'(x1 != 0);
        x0 = ((x0 << 1) & 31) | (((x0 >> 4) ^ (x0 >> 3)) & 1);
        x1 = ((x1 << 1) & 31) | (((x1 >> 4) ^ (x1 >> 3)) & 1);
      end
      total++; if (stim_b !== {5'(x1), 5'(x0)}) $display("FAIL b_stim k=%0d: got %h want %h", k, stim_b, {5'(x1), 5'(x0)}); else passed++;
    end
    en = 1'b0;
    e = e > 7 ? 7 : e;
    total++; if (done_b !== 1'b1) $display("FAIL b_done: got %b want 1", done_b); else passed++;
    total++; if (err_b !== 3'(e)) $display("FAIL b_saturate: got %0d want %0d", err_b, e); else passed++;
    total++; if (fail_b !== 1'b1 || fch_b !== 1'b0 || fvec_b !== 32'd0) $display("FAIL b_first: got %b/%0d/%0d want 1/0/0", fail_b, fch_b, fvec_b); else passed++;
  endtask

  task automatic set_stuck();
    foreach (fm[v]) fm[v] = (v < NV && ((2 + v) % 2) == 0) ? 12'h100 : 12'h000;
  endtask

  task automatic test_fault();
    set_stuck();
    run_a(0, 0);
  endtask

  task automatic test_simul();
    foreach (fm[v]) fm[v] = 12'h000;
    fm[5] = 12'h0FF;
    run_a(0, 0);
    total++; if (errh[6] !== 0 || errh[7] !== 2) $display("FAIL simul_step: got %0d->%0d want 0->2", errh[6], errh[7]); else passed++;
  endtask

  task automatic test_sparse();
    foreach (fm[v]) fm[v] = (v < NV && $urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h000;
    run_a(0, 0);
    run_a(1, 1);
  endtask

  task automatic test_rerun();
    set_stuck();
    start_a = 1'b1;
    tick(0);
    start_a = 1'b0;
    repeat (7) tick(1);
    en = 1'b0;
    total++; if (err_a !== 16'd3) $display("FAIL rerun_mid_err: got %0d want 3", err_a); else passed++;
    rst = 1'b1;
    tick(0);
    rst = 1'b0;
    total++; if (stim_a !== 12'h210) $display("FAIL rerun_rst_stim: got %h want 210", stim_a); else passed++;
    total++; if (err_a !== 16'd0 || fail_a !== 1'b0 || fch_a !== 2'd0 || fvec_a !== 32'd0) $display("FAIL rerun_rst_results: got %0d/%b/%0d/%0d want all 0", err_a, fail_a, fch_a, fvec_a); else passed++;
    total++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL rerun_rst_state: got %b/%b want 0/0", busy_a, done_a); else passed++;
    run_a(0, 0);
    foreach (fm[v]) fm[v] = 12'h000;
    run_a(1, 0);
  endtask

  initial begin
    foreach (fm[v]) fm[v] = 12'h000;
    test_reset();
    test_invert();
    test_lfsr_sat();
    test_fault();
    test_simul();
    test_sparse();
    test_rerun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
